// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART TX channel (din/send/txbusy) between N byte requesters.
// Optional message lock is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arb #(
    parameter int N     = 4,
    parameter int TMO_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [8*N-1:0]   req_data,
    input  logic [N-1:0]     req_last,
    output logic [N-1:0]     ack,
    output logic [7:0]       tx_din,
    output logic             tx_send,
    input  logic             tx_busy,
    output logic [2:0]       owner,
    output logic             tmo_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    localparam logic [N-1:0]     ONE_N    = N'(1'b1);
    localparam logic [TMO_W-1:0] TMO_LAST = {TMO_W{1'b1}};

    state_t           state_r;
    logic [N-1:0]     ack_r;
    logic [7:0]       tx_din_r;
    logic             tx_send_r;
    logic [2:0]       owner_r;
    logic             tmo_err_r;
    logic [2:0]       rr_r;
    logic [TMO_W-1:0] tmo_cnt_r;

    logic [N-1:0]     elig_s;
    logic             gnt_vld_s;
    logic [2:0]       gnt_idx_s;
    logic [7:0]       gnt_byte_s;
    logic [2:0]       rr_next_s;
    logic             grant_fire_s;
    logic             tmo_fire_s;

`ifdef UART_ARB_LOCK_EN
    logic             lock_r;
    logic             gnt_last_s;

    // While a message is locked only its owner may be granted again.
    assign elig_s     = lock_r ? (req & (ONE_N << owner_r)) : req;
    assign gnt_last_s = |(req_last & (ONE_N << gnt_idx_s));
`else
    logic             unused_last_s;

    assign elig_s        = req;
    assign unused_last_s = ^req_last;
`endif

    // First eligible requester scanning upward from the rr pointer, wrapping at N.
    always_comb begin : pick
        int   idx_v;
        logic hit_v;
        gnt_vld_s  = 1'b0;
        gnt_idx_s  = 3'd0;
        gnt_byte_s = 8'd0;
        idx_v      = 0;
        hit_v      = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx_v      = (int'(rr_r) + k) % N;
            hit_v      = !gnt_vld_s && (|(elig_s & (ONE_N << idx_v)));
            gnt_idx_s  = hit_v ? 3'(idx_v) : gnt_idx_s;
            gnt_byte_s = hit_v ? 8'(req_data >> (8 * idx_v)) : gnt_byte_s;
            gnt_vld_s  = gnt_vld_s | hit_v;
        end
    end

    assign rr_next_s    = (gnt_idx_s == 3'(N - 1)) ? 3'd0 : (gnt_idx_s + 3'd1);
    assign grant_fire_s = (state_r == ST_IDLE) && !tx_busy && gnt_vld_s;
    assign tmo_fire_s   = (state_r == ST_START) && !tx_busy && (tmo_cnt_r == TMO_LAST);

    // Grant / send / frame-wait sequencer with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            ack_r     <= {N{1'b0}};
            tx_din_r  <= 8'd0;
            tx_send_r <= 1'b0;
            owner_r   <= 3'd0;
            tmo_err_r <= 1'b0;
            rr_r      <= 3'd0;
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else begin
            ack_r     <= {N{1'b0}};
            tmo_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    tx_send_r <= 1'b0;
                    if (grant_fire_s) begin
                        tx_din_r  <= gnt_byte_s;
                        owner_r   <= gnt_idx_s;
                        ack_r     <= ONE_N << gnt_idx_s;
                        rr_r      <= rr_next_s;
                        tmo_cnt_r <= {TMO_W{1'b0}};
                        state_r   <= ST_START;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (tx_busy) begin
                        tx_send_r <= 1'b0;
                        state_r   <= ST_BUSY;
                    end else if (tmo_fire_s) begin
                        // UART never answered: the byte is dropped, it was already acked.
                        tx_send_r <= 1'b0;
                        tmo_err_r <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        tx_send_r <= 1'b1;
                        tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_BUSY: begin
                    tx_send_r <= 1'b0;
                    if (!tx_busy) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                default: begin
                    tx_send_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_ARB_LOCK_EN
    // Lock follows the last accepted byte; a timeout always releases it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_r <= 1'b0;
        end else if (tmo_fire_s) begin
            lock_r <= 1'b0;
        end else if (grant_fire_s) begin
            lock_r <= !gnt_last_s;
        end else begin
            lock_r <= lock_r;
        end
    end
`endif

    assign ack     = ack_r;
    assign tx_din  = tx_din_r;
    assign tx_send = tx_send_r;
    assign owner   = owner_r;
    assign tmo_err = tmo_err_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: requester queues, a small UART model and
// expected-byte / expected-ack scoreboards.
module tb_uart_tx_arb;

    localparam int N     = 4;
    localparam int TMO_W = 12;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   ack;
    logic [7:0]     tx_din;
    logic           tx_send;
    logic           tx_busy;
    logic [2:0]     owner;
    logic           tmo_err;

    int checks_r = 0;
    int errors_r = 0;

    logic [7:0] exp_byte_q[$];
    int         exp_ack_q[$];

    logic [8:0] src_mem [N][16];
    int         src_rd  [N];
    int         src_wr  [N];

    logic model_en = 1'b1;
    logic busy_q   = 1'b0;
    int   tmo_seen = 0;

    uart_tx_arb #(.N(N), .TMO_W(TMO_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .ack      (ack),
        .tx_din   (tx_din),
        .tx_send  (tx_send),
        .tx_busy  (tx_busy),
        .owner    (owner),
        .tmo_err  (tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic load(input int i, input logic [7:0] b, input logic last);
        src_mem[i][src_wr[i]] = {last, b};
        src_wr[i]++;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        req = '0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        logic timed_out;
        logic pend;
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            pend = 1'b0;
            for (int i = 0; i < N; i++) pend = pend | (src_rd[i] < src_wr[i]);
            if (exp_byte_q.size() == 0 && exp_ack_q.size() == 0 && !pend &&
                !tx_busy && !tx_send) begin
                timed_out = 1'b0;
                break;
            end
        end
        check_eq(tag, 32'(timed_out), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    // Requesters: present the head byte, advance on ack (visible from the next edge).
    initial begin
        clear_sources();
        req_data = '0;
        req_last = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (ack[i] && src_rd[i] < src_wr[i]) src_rd[i]++;
                req[i]            = (src_rd[i] < src_wr[i]);
                req_data[8*i +: 8] = src_mem[i][src_rd[i] % 16][7:0];
                req_last[i]       = src_mem[i][src_rd[i] % 16][8];
            end
        end
    end

    always @(posedge clk) busy_q <= tx_busy;

    // Ack monitor: one-hot, expected owner, never while the UART was busy.
    initial forever begin
        @(negedge clk);
        if (reset && |ack) begin
            int idx;
            idx = 0;
            for (int i = 0; i < N; i++) if (ack[i]) idx = i;
            check_eq("ack_onehot", 32'($countones(ack)), 32'd1);
            check_eq("ack_while_busy", 32'(busy_q), 32'd0);
            if (exp_ack_q.size() == 0) begin
                check_eq("ack_unexpected", 32'(exp_ack_q.size()), 32'd1);
            end else begin
                int e;
                e = exp_ack_q.pop_front();
                check_eq("ack_idx", 32'(idx), 32'(e));
                check_eq("owner", 32'(owner), 32'(e));
            end
        end
        if (tmo_err) tmo_seen++;
    end

    // UART model: answer send after 3 cycles, then busy for 6 cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (model_en && reset && tx_send === 1'b1 && !tx_busy) begin
                logic [7:0] b;
                b = tx_din;
                if (exp_byte_q.size() == 0) begin
                    check_eq("byte_unexpected", 32'(exp_byte_q.size()), 32'd1);
                end else begin
                    check_eq("tx_din", 32'(b), 32'(exp_byte_q.pop_front()));
                end
                repeat (3) begin
                    @(negedge clk);
                    check_eq("send_hold", 32'(tx_send), 32'd1);
                    check_eq("din_hold", 32'(tx_din), 32'(b));
                end
                tx_busy = 1'b1;
                @(negedge clk);
                check_eq("send_drop", 32'(tx_send), 32'd0);
                repeat (5) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int found;
        reset = 1'b0;
        #3;
        check_eq("rst_send_async", 32'(tx_send), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_din", 32'(tx_din), 32'd0);
        check_eq("rst_owner", 32'(owner), 32'd0);
        check_eq("rst_tmo", 32'(tmo_err), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // single request on requester 2
        exp_byte_q.push_back(8'h41); exp_ack_q.push_back(2);
        load(2, 8'h41, 1'b1);
        wait_drain("single_drain", 200);

        // wrap: rr is now 3, requesters 3 and 0 together
        exp_byte_q.push_back(8'h23); exp_ack_q.push_back(3);
        exp_byte_q.push_back(8'h20); exp_ack_q.push_back(0);
        load(0, 8'h20, 1'b1);
        load(3, 8'h23, 1'b1);
        wait_drain("wrap_drain", 300);

        // asynchronous reset while in START
        model_en = 1'b0;
        exp_ack_q.push_back(1);
        load(1, 8'h55, 1'b1);
        found = 0;
        for (int c = 0; c < 50 && found == 0; c++) begin
            @(negedge clk);
            if (tx_send) found = 1;
        end
        check_eq("rst_mid_start_seen", 32'(found), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_mid_send", 32'(tx_send), 32'd0);
        check_eq("rst_mid_ack", 32'(ack), 32'd0);
        check_eq("rst_mid_owner", 32'(owner), 32'd0);
        clear_sources();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_en = 1'b1;
        check_eq("rst_mid_ackq", 32'(exp_ack_q.size()), 32'd0);

        // contention: all four, two bytes each, rr restarts at 0
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                exp_byte_q.push_back(8'(8'h10 + i));
                exp_ack_q.push_back(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            load(i, 8'(8'h10 + i), 1'b1);
            load(i, 8'(8'h10 + i), 1'b1);
        end
        wait_drain("contention_drain", 1000);

        // send timeout: UART never raises busy
        model_en = 1'b0;
        exp_ack_q.push_back(1);
        load(1, 8'h77, 1'b1);
        found = 0;
        for (int c = 0; c < 50 && found == 0; c++) begin
            @(negedge clk);
            if (tx_send) found = 1;
        end
        check_eq("tmo_send_seen", 32'(found), 32'd1);
        cnt = 0;
        while (tx_send && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
        check_eq("tmo_send_cycles", 32'(cnt), 32'((1 << TMO_W) - 1));
        check_eq("tmo_pulse", 32'(tmo_err), 32'd1);
        check_eq("tmo_send_low", 32'(tx_send), 32'd0);
        @(negedge clk);
        check_eq("tmo_one_cycle", 32'(tmo_err), 32'd0);
        model_en = 1'b1;
        wait_drain("tmo_drain", 100);

        // three-byte message from requester 0 against a pending requester 1
`ifdef UART_ARB_LOCK_EN
        exp_byte_q.push_back(8'h30); exp_ack_q.push_back(0);
        exp_byte_q.push_back(8'h31); exp_ack_q.push_back(0);
        exp_byte_q.push_back(8'h32); exp_ack_q.push_back(0);
        exp_byte_q.push_back(8'h40); exp_ack_q.push_back(1);
`else
        exp_byte_q.push_back(8'h30); exp_ack_q.push_back(0);
        exp_byte_q.push_back(8'h40); exp_ack_q.push_back(1);
        exp_byte_q.push_back(8'h31); exp_ack_q.push_back(0);
        exp_byte_q.push_back(8'h32); exp_ack_q.push_back(0);
`endif
        load(0, 8'h30, 1'b0);
        load(0, 8'h31, 1'b0);
        load(0, 8'h32, 1'b1);
        load(1, 8'h40, 1'b1);
        wait_drain("lock_drain", 600);

        check_eq("tmo_total", 32'(tmo_seen), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
